// File: rtl/module_tick_ctrl.sv
// Tick/clock-divider run controller: holds the divisor, runs continuous or counted bursts, emits tick, clk_div and done.
// Optional build macro TICK_CTRL_SHADOW_EN adds shadowed reconfiguration while running.
module module_tick_ctrl #(
   parameter int CNT_W       = 15,
   parameter int DEFAULT_DIV = 27000,
   parameter int BURST_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_div,
   input  logic               cfg_mode,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic               start,
   input  logic               stop,
   output logic               tick,
   output logic               clk_div,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] tick_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]   DIV_RST   = CNT_W'(DEFAULT_DIV);
   localparam logic [BURST_W-1:0] BURST_RST = BURST_W'(1);

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [CNT_W-1:0]   div_r;
   logic               mode_r;
   logic [BURST_W-1:0] burst_r;

   logic               wrap;
   logic               cfg_take;
   logic               burst_hit;
   logic [BURST_W-1:0] cnt_next;

   // A zero divisor or burst length would never terminate, so both clamp to 1.
   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
      return (d == '0) ? CNT_W'(1) : d;
   endfunction

   function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] b);
      return (b == '0) ? BURST_W'(1) : b;
   endfunction

   function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
      return (v == '1) ? v : v + BURST_W'(1);
   endfunction

`ifdef TICK_CTRL_SHADOW_EN
   logic [CNT_W-1:0]   sh_div;
   logic               sh_mode;
   logic [BURST_W-1:0] sh_burst;
   logic               pending;

   assign cfg_ready = 1'b1;
`else
   assign cfg_ready = (state == ST_IDLE);
`endif

   assign busy      = (state == ST_RUN);
   assign cfg_take  = cfg_valid && cfg_ready;
   assign wrap      = (state == ST_RUN) && (counter == div_r - CNT_W'(1));
   assign cnt_next  = sat_inc(tick_cnt);
   assign burst_hit = mode_r && (cnt_next == burst_r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         counter  <= '0;
         tick     <= 1'b0;
         clk_div  <= 1'b0;
         done     <= 1'b0;
         tick_cnt <= '0;
         div_r    <= DIV_RST;
         mode_r   <= 1'b0;
         burst_r  <= BURST_RST;
`ifdef TICK_CTRL_SHADOW_EN
         sh_div   <= DIV_RST;
         sh_mode  <= 1'b0;
         sh_burst <= BURST_RST;
         pending  <= 1'b0;
`endif
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_take) begin
                  div_r   <= clamp_div(cfg_div);
                  mode_r  <= cfg_mode;
                  burst_r <= clamp_burst(cfg_burst);
               end
               // stop wins over a simultaneous start
               if (start && !stop) begin
                  state    <= ST_RUN;
                  counter  <= '0;
                  tick_cnt <= '0;
               end
            end

            ST_RUN: begin
               if (wrap) begin
                  tick     <= 1'b1;
                  counter  <= '0;
                  tick_cnt <= cnt_next;
                  clk_div  <= ~clk_div;
               end else begin
                  counter <= counter + CNT_W'(1);
               end

               // A tick coinciding with stop still pulses, but stop beats the DONE transition.
               if (stop) begin
                  state   <= ST_IDLE;
                  counter <= '0;
                  clk_div <= 1'b0;
               end else if (wrap && burst_hit) begin
                  state   <= ST_DONE;
                  counter <= '0;
                  clk_div <= 1'b0;
               end

`ifdef TICK_CTRL_SHADOW_EN
               // Shadow values land on the wrap edge so the new divisor governs a whole period.
               if (stop) begin
                  pending <= 1'b0;
               end else begin
                  if (wrap && pending) begin
                     div_r   <= sh_div;
                     mode_r  <= sh_mode;
                     burst_r <= sh_burst;
                     pending <= 1'b0;
                  end
                  if (cfg_take) begin
                     sh_div   <= clamp_div(cfg_div);
                     sh_mode  <= cfg_mode;
                     sh_burst <= clamp_burst(cfg_burst);
                     pending  <= 1'b1;
                  end
               end
`endif
            end

            ST_DONE: begin
               done    <= 1'b1;
               clk_div <= 1'b0;
               state   <= ST_IDLE;
`ifdef TICK_CTRL_SHADOW_EN
               if (cfg_take) begin
                  div_r   <= clamp_div(cfg_div);
                  mode_r  <= cfg_mode;
                  burst_r <= clamp_burst(cfg_burst);
               end
`endif
            end

            default: begin
               state   <= ST_IDLE;
               counter <= '0;
               clk_div <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_tick_ctrl.sv
// Directed bench for module_tick_ctrl: burst, continuous, stop races, run-time config and async reset.
module tb_module_tick_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [14:0] cfg_div;
   logic       cfg_mode;
   logic [7:0] cfg_burst;
   logic       start;
   logic       stop;
   logic       tick;
   logic       clk_div;
   logic       busy;
   logic       done;
   logic [7:0] tick_cnt;

   int checks = 0;
   int errors = 0;

   module_tick_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .cfg_burst (cfg_burst),
      .start     (start),
      .stop      (stop),
      .tick      (tick),
      .clk_div   (clk_div),
      .busy      (busy),
      .done      (done),
      .tick_cnt  (tick_cnt)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " tick"},      tick,      1'b0);
      chk({tag, " clk_div"},   clk_div,   1'b0);
      chk({tag, " busy"},      busy,      1'b0);
      chk({tag, " done"},      done,      1'b0);
      chk({tag, " cfg_ready"}, cfg_ready, 1'b1);
   endtask

   // Steps until tick, returning the cycle count; the budget expiring is reported as a failure.
   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < budget);
   endtask

   initial begin
      int  n;
      bit  exp_tick;
      bit  saw_done;

      rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_mode = 1'b0; cfg_burst = '0;
      start = 1'b0; stop = 1'b0;
      step(); step();
      chk_idle_outputs("reset");
      chk("reset tick_cnt", tick_cnt, 8'd0);
      rst = 1'b0;
      step();

      // Burst D=4 x3, config captured on the start edge
      cfg_valid = 1'b1; cfg_div = 15'd4; cfg_mode = 1'b1; cfg_burst = 8'd3; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      chk("burst busy c0", busy, 1'b1);
      chk("burst cfg_ready c0", cfg_ready, 1'b0);
      for (int c = 1; c <= 14; c++) begin
         step();
         exp_tick = (c == 4 || c == 8 || c == 12);
         chk($sformatf("burst tick c%0d", c), tick, exp_tick);
         chk($sformatf("burst done c%0d", c), done, (c == 13));
         if (c == 4)  chk("burst clk_div c4", clk_div, 1'b1);
         if (c == 8)  chk("burst clk_div c8", clk_div, 1'b0);
         if (c == 12) chk("burst busy c12", busy, 1'b0);
      end
      chk("burst tick_cnt", tick_cnt, 8'd3);
      chk_idle_outputs("burst end");

      // Continuous with D=0 (treated as 1), stop coincides with the 5th tick
      cfg_valid = 1'b1; cfg_div = 15'd0; cfg_mode = 1'b0; cfg_burst = 8'd0;
      step();
      cfg_valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("cont tick c%0d", c), tick, 1'b1);
         if (done) saw_done = 1'b1;
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("cont tick c5", tick, 1'b1);
      chk("cont busy c5", busy, 1'b0);
      chk("cont tick_cnt", tick_cnt, 8'd5);
      chk("cont clk_div c5", clk_div, 1'b0);
      step();
      if (done) saw_done = 1'b1;
      chk("cont no done", saw_done, 1'b0);
      chk_idle_outputs("cont end");
      chk("cont tick_cnt hold", tick_cnt, 8'd5);

      // start and stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("start+stop busy", busy, 1'b0);

      // Burst 2 with D=3, stop on the edge of the 2nd tick
      cfg_valid = 1'b1; cfg_div = 15'd3; cfg_mode = 1'b1; cfg_burst = 8'd2; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         step();
         chk($sformatf("race tick c%0d", c), tick, (c == 3));
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("race tick c6", tick, 1'b1);
      chk("race busy c6", busy, 1'b0);
      chk("race tick_cnt", tick_cnt, 8'd2);
      step();
      chk("race done c7", done, 1'b0);
      step();
      chk("race done c8", done, 1'b0);
      chk_idle_outputs("race end");

      // Config write while running, D=5 continuous, new D=2
      cfg_valid = 1'b1; cfg_div = 15'd5; cfg_mode = 1'b0; cfg_burst = 8'd1; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      step();
      cfg_valid = 1'b1; cfg_div = 15'd2;
`ifdef TICK_CTRL_SHADOW_EN
      chk("runcfg cfg_ready", cfg_ready, 1'b1);
`else
      chk("runcfg cfg_ready", cfg_ready, 1'b0);
`endif
      for (int c = 2; c <= 11; c++) begin
         step();
         cfg_valid = 1'b0;
`ifdef TICK_CTRL_SHADOW_EN
         exp_tick = (c == 5 || c == 7 || c == 9 || c == 11);
`else
         exp_tick = (c == 5 || c == 10);
`endif
         chk($sformatf("runcfg tick c%0d", c), tick, exp_tick);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      chk("runcfg stopped busy", busy, 1'b0);

      // Asynchronous reset in the middle of a run
      cfg_valid = 1'b1; cfg_div = 15'd3; cfg_mode = 1'b1; cfg_burst = 8'd5; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      step(); step(); step();
      chk("pre-rst tick c3", tick, 1'b1);
      chk("pre-rst clk_div c3", clk_div, 1'b1);
      chk("pre-rst tick_cnt c3", tick_cnt, 8'd1);
      #2 rst = 1'b1;
      #1;
      chk_idle_outputs("async rst");
      chk("async rst tick_cnt", tick_cnt, 8'd0);
      step();
      rst = 1'b0;

      // Default divisor restored: ticks 27000 cycles apart
      start = 1'b1;
      step();
      start = 1'b0;
      chk("dflt busy c0", busy, 1'b1);
      wait_tick(30000, n);
      chk("dflt first tick cycle", n, 27000);
      chk("dflt clk_div after 1st", clk_div, 1'b1);
      chk("dflt tick_cnt after 1st", tick_cnt, 8'd1);
      chk("dflt busy running", busy, 1'b1);
      wait_tick(30000, n);
      chk("dflt second tick gap", n, 27000);
      chk("dflt clk_div after 2nd", clk_div, 1'b0);
      chk("dflt tick_cnt after 2nd", tick_cnt, 8'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("dflt stop busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
